id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID→EX pipeline register, directly downstream of the instruction control decoder in the rv32 pipelined core.
- Captures the decoder's control bundle together with operand, immediate and PC data each cycle.
- Contains load-use hazard detection: it stalls IF/ID and inserts a bubble.
- Accepts an EX-stage redirect flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-file address width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_npc_op  in  2  from decoder.
- id_rf_wsel  in  2  from decoder.
- id_rf_we  in  1  from decoder.
- id_ext_op  in  3  from decoder.
- id_alu_op  in  3  from decoder.
- id_alub_sel  in  1  from decoder.
- id_ram_we  in  1  from decoder.
- id_pc  in  XLEN  instruction PC.
- id_pc4  in  XLEN  PC+4.
- id_rd1  in  XLEN  rs1 read data.
- id_rd2  in  XLEN  rs2 read data.
- id_ext  in  XLEN  extended immediate.
- id_rs1  in  REG_AW  rs1 index.
- id_rs2  in  REG_AW  rs2 index.
- id_rd  in  REG_AW  rd index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- ex_flush  in  1  EX redirect: taken branch, JAL or JALR.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_npc_op, ex_rf_wsel, ex_rf_we, ex_ext_op, ex_alu_op, ex_alub_sel, ex_ram_we  out  as inputs  registered control.
- ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_ext  out  XLEN  registered data.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices.
- stall_if_id  out  1  combinational; hold PC and IF/ID this cycle.
- flush_if_id  out  1  combinational; equals ex_flush.

Behaviour:
- Reset (rst_n=0, async):
  - ex_valid, ex_rf_we, ex_ram_we and all data/index outputs = 0.
  - ex_npc_op = `NPC_PC4`; ex_rf_wsel = `WB_ALU`; ex_alu_op, ex_ext_op, ex_alub_sel = 0.
  - Optional counters = 0.
  - Reset mid-operation discards the EX contents immediately and asynchronously.
- Hazard detect (combinational), load_use = ex_valid & ex_rf_we & (ex_rf_wsel==`WB_DRAM`) & (ex_rd!=0) & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- stall_if_id = load_use & ~ex_flush.
- Register update on each rising clk, in priority order:
  1. ex_flush=1: load a bubble. A bubble is ex_valid=0, ex_rf_we=0, ex_ram_we=0, ex_npc_op=`NPC_PC4`. The other fields are don't-care and are held at their previous values. Flush beats stall: the ID instruction is on the wrong path.
  2. Else if load_use=1: load a bubble. IF/ID holds because stall_if_id=1, so the ID instruction is re-presented next cycle and hazard detect re-evaluates it. That evaluation clears because EX now holds the bubble. Result: exactly one stall cycle per load-use.
  3. Else if id_valid=0: load a bubble.
  4. Else: capture all id_* into ex_*, ex_valid=1.
- Latency: 1 cycle ID→EX. No bypass path.
- rd==0: a load to x0 never stalls.
- Store after load:
  - Uses rs2 data. This is a stall when id_rs2_used=1 and the index matches ex_rd.
  - It is a real stall; no MEM→EX forward is assumed by this block.
- Back-to-back loads: each is evaluated independently. A dependent load after a load stalls once.
- Simultaneous ex_flush and load_use: a single bubble is loaded, stall_if_id=0, flush_if_id=1.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined, add outputs perf_stall_cnt and perf_flush_cnt (CNT_W each):
  - perf_stall_cnt increments on every cycle with stall_if_id=1.
  - perf_flush_cnt increments on every cycle with ex_flush=1.
  - Both saturate at all-ones (no wrap) and clear on reset.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared defines header, the same one used by the decoder, holds:
  - `NPC_PC4`, `NPC_BEQ`, `NPC_JAL`, `NPC_JALR`.
  - `WB_ALU`, `WB_DRAM`, `WB_PC4`, `WB_EXT`.
  - `ALU_*` and `EXT_*` codes.
- No new typedefs.
- One sub-module, hazard_detect: purely combinational load_use / stall_if_id logic, instantiated once.
- The register bank stays in id_ex_pipe.

Test Plan:
1. Reset: rst_n=0 mid-stream with ex_valid=1 → ex_valid=0, ex_rf_we=0, ex_ram_we=0, ex_npc_op=`NPC_PC4`, all without a clock edge.
2. Plain pass-through: add x3,x1,x2 with id_rd1=5, id_rd2=7 → next cycle ex_valid=1, ex_rd=3, ex_rd1=5, ex_rd2=7, ex_alu_op=`ALU_ADD`.
3. Load-use: lw x5 then add x6,x5,x1 → stall_if_id=1 for exactly 1 cycle, a bubble in EX, then the add captured with ex_rs1=5.
4. Load to x0: lw x0 then add x6,x0,x1 → no stall.
5. Flush vs stall: load_use=1 and ex_flush=1 in the same cycle → stall_if_id=0, bubble loaded, flush_if_id=1.
6. Counters (ID_EX_PERF_CNT_EN): 3 load-use events and 2 flushes → perf_stall_cnt=3, perf_flush_cnt=2. Preload at all-ones plus one more stall → count stays all-ones.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared control-code definitions for the rv32 decoder and the ID/EX pipeline register.
// Codes exist both as `defines (decoder-compatible) and as package localparams.
`ifndef ID_EX_PIPE_DEFINES
`define ID_EX_PIPE_DEFINES
`define NPC_PC4  2'b00
`define NPC_BEQ  2'b01
`define NPC_JAL  2'b10
`define NPC_JALR 2'b11
`define WB_ALU   2'b00
`define WB_DRAM  2'b01
`define WB_PC4   2'b10
`define WB_EXT   2'b11
`define ALU_ADD  3'b000
`define ALU_SUB  3'b001
`define ALU_AND  3'b010
`define ALU_OR   3'b011
`define ALU_XOR  3'b100
`define ALU_SLL  3'b101
`define ALU_SRL  3'b110
`define ALU_SRA  3'b111
`define EXT_I    3'b000
`define EXT_S    3'b001
`define EXT_B    3'b010
`define EXT_U    3'b011
`define EXT_J    3'b100
`endif

package id_ex_pipe_pkg;
  localparam logic [1:0] NPC_PC4  = `NPC_PC4;
  localparam logic [1:0] NPC_BEQ  = `NPC_BEQ;
  localparam logic [1:0] NPC_JAL  = `NPC_JAL;
  localparam logic [1:0] NPC_JALR = `NPC_JALR;
  localparam logic [1:0] WB_ALU   = `WB_ALU;
  localparam logic [1:0] WB_DRAM  = `WB_DRAM;
  localparam logic [1:0] WB_PC4   = `WB_PC4;
  localparam logic [1:0] WB_EXT   = `WB_EXT;
  localparam logic [2:0] ALU_ADD  = `ALU_ADD;
  localparam logic [2:0] ALU_SUB  = `ALU_SUB;
  localparam logic [2:0] EXT_I    = `EXT_I;
  localparam logic [2:0] EXT_S    = `EXT_S;
  localparam logic [2:0] EXT_J    = `EXT_J;
endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load sitting in EX.
// Purely combinational; a redirect flush suppresses the stall.
module id_ex_pipe_hazard_detect
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_rf_we,
  input  logic [1:0]        ex_rf_wsel,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_flush,
  output logic              load_use,
  output logic              stall_if_id
);

  logic ex_is_load;
  logic rs_match;

  always_comb begin
    ex_is_load  = ex_valid & ex_rf_we & (ex_rf_wsel == WB_DRAM) & (ex_rd != '0);
    rs_match    = (id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd));
    load_use    = ex_is_load & id_valid & rs_match;
    stall_if_id = load_use & ~ex_flush;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use bubble insertion and EX redirect flush.
// Optional saturating stall/flush counters under ID_EX_PERF_CNT_EN.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_npc_op,
  input  logic [1:0]        id_rf_wsel,
  input  logic              id_rf_we,
  input  logic [2:0]        id_ext_op,
  input  logic [2:0]        id_alu_op,
  input  logic              id_alub_sel,
  input  logic              id_ram_we,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_pc4,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_ext,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [1:0]        ex_npc_op,
  output logic [1:0]        ex_rf_wsel,
  output logic              ex_rf_we,
  output logic [2:0]        ex_ext_op,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alub_sel,
  output logic              ex_ram_we,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc4,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_ext,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
  output logic              stall_if_id,
  output logic              flush_if_id
);

  logic load_use;
  logic bubble;

  id_ex_pipe_hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_rf_we    (ex_rf_we),
    .ex_rf_wsel  (ex_rf_wsel),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_flush    (ex_flush),
    .load_use    (load_use),
    .stall_if_id (stall_if_id)
  );

  assign flush_if_id = ex_flush;
  // Flush, load-use and an empty ID slot all collapse to the same bubble.
  assign bubble      = ex_flush | load_use | ~id_valid;

  // Bubbles only clear the side-effect fields; data fields keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_npc_op   <= NPC_PC4;
      ex_rf_wsel  <= WB_ALU;
      ex_rf_we    <= 1'b0;
      ex_ext_op   <= '0;
      ex_alu_op   <= '0;
      ex_alub_sel <= 1'b0;
      ex_ram_we   <= 1'b0;
      ex_pc       <= '0;
      ex_pc4      <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_ext      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_rf_we    <= 1'b0;
      ex_ram_we   <= 1'b0;
      ex_npc_op   <= NPC_PC4;
    end else begin
      ex_valid    <= 1'b1;
      ex_npc_op   <= id_npc_op;
      ex_rf_wsel  <= id_rf_wsel;
      ex_rf_we    <= id_rf_we;
      ex_ext_op   <= id_ext_op;
      ex_alu_op   <= id_alu_op;
      ex_alub_sel <= id_alub_sel;
      ex_ram_we   <= id_ram_we;
      ex_pc       <= id_pc;
      ex_pc4      <= id_pc4;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_ext      <= id_ext;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if_id && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (ex_flush && (perf_flush_cnt != '1))    perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; covers counters when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [1:0]  id_npc_op, id_rf_wsel;
  logic        id_rf_we, id_alub_sel, id_ram_we;
  logic [2:0]  id_ext_op, id_alu_op;
  logic [31:0] id_pc, id_pc4, id_rd1, id_rd2, id_ext;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, ex_flush;
  logic        ex_valid, ex_rf_we, ex_alub_sel, ex_ram_we;
  logic [1:0]  ex_npc_op, ex_rf_wsel;
  logic [2:0]  ex_ext_op, ex_alu_op;
  logic [31:0] ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_ext;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        stall_if_id, flush_if_id;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] pc_n = 32'h100;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_npc_op(id_npc_op),
    .id_rf_wsel(id_rf_wsel), .id_rf_we(id_rf_we), .id_ext_op(id_ext_op),
    .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel), .id_ram_we(id_ram_we),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ext(id_ext),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_flush(ex_flush), .ex_valid(ex_valid),
    .ex_npc_op(ex_npc_op), .ex_rf_wsel(ex_rf_wsel), .ex_rf_we(ex_rf_we),
    .ex_ext_op(ex_ext_op), .ex_alu_op(ex_alu_op), .ex_alub_sel(ex_alub_sel),
    .ex_ram_we(ex_ram_we), .ex_pc(ex_pc), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_ext(ex_ext), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
`ifdef ID_EX_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_common(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_pc = pc_n; id_pc4 = pc_n + 32'd4; pc_n = pc_n + 32'd4;
    id_npc_op = NPC_PC4; id_alu_op = ALU_ADD; id_ram_we = 1'b0;
  endtask

  task automatic drv_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] a, input logic [31:0] b);
    drv_common(rd, rs1, rs2);
    id_rf_wsel = WB_ALU; id_rf_we = 1'b1; id_ext_op = EXT_I; id_alub_sel = 1'b0;
    id_rd1 = a; id_rd2 = b; id_ext = 32'd0; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
  endtask

  task automatic drv_load(input logic [4:0] rd, input logic [4:0] rs1);
    drv_common(rd, rs1, 5'd0);
    id_rf_wsel = WB_DRAM; id_rf_we = 1'b1; id_ext_op = EXT_I; id_alub_sel = 1'b1;
    id_rd1 = 32'h1000; id_rd2 = 32'd0; id_ext = 32'd8; id_rs1_used = 1'b1; id_rs2_used = 1'b0;
  endtask

  task automatic drv_store(input logic [4:0] rs1, input logic [4:0] rs2);
    drv_common(5'd0, rs1, rs2);
    id_rf_wsel = WB_ALU; id_rf_we = 1'b0; id_ext_op = EXT_S; id_alub_sel = 1'b1;
    id_ram_we = 1'b1; id_rd1 = 32'h2000; id_rd2 = 32'hCAFE; id_ext = 32'd4;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1;
  endtask

  task automatic drv_jal(input logic [4:0] rd);
    drv_common(rd, 5'd0, 5'd0);
    id_npc_op = NPC_JAL; id_rf_wsel = WB_PC4; id_rf_we = 1'b1; id_ext_op = EXT_J;
    id_alub_sel = 1'b1; id_rd1 = 32'd0; id_rd2 = 32'd0; id_ext = 32'h40;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
  endtask

  task automatic drv_nop;
    id_valid = 1'b0; id_rf_we = 1'b0; id_ram_we = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ex_flush = 1'b0;
    id_npc_op = '0; id_rf_wsel = '0; id_ext_op = '0; id_alu_op = '0; id_alub_sel = 1'b0;
    id_pc = '0; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_ext = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    drv_nop();
    #2;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_wsel", 32'(ex_rf_wsel), 32'(WB_ALU));
    #2 rst_n = 1'b1;

    // Plain pass-through: add x3,x1,x2
    @(posedge clk); #1;
    drv_alu(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
    tick();
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_rd", 32'(ex_rd), 32'd3);
    check("add_rd1", ex_rd1, 32'd5);
    check("add_rd2", ex_rd2, 32'd7);
    check("add_alu", 32'(ex_alu_op), 32'(ALU_ADD));
    check("add_pc", ex_pc, 32'h100);
    check("add_pc4", ex_pc4, 32'h104);

    // Async reset mid-stream with a JAL in EX
    drv_jal(5'd1);
    tick();
    check("jal_npc", 32'(ex_npc_op), 32'(NPC_JAL));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid), 32'd0);
    check("arst_rf_we", 32'(ex_rf_we), 32'd0);
    check("arst_ram_we", 32'(ex_ram_we), 32'd0);
    check("arst_npc", 32'(ex_npc_op), 32'(NPC_PC4));
    check("arst_rd", 32'(ex_rd), 32'd0);
    #1 rst_n = 1'b1;

    // Load-use: lw x5 ; add x6,x5,x1
    @(posedge clk); #1;
    drv_load(5'd5, 5'd2);
    #1;
    check("lw_nostall", 32'(stall_if_id), 32'd0);
    tick();
    drv_alu(5'd6, 5'd5, 5'd1, 32'd11, 32'd22);
    #1;
    check("lu_stall", 32'(stall_if_id), 32'd1);
    check("lu_flush", 32'(flush_if_id), 32'd0);
    tick();
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_bub_we", 32'(ex_rf_we), 32'd0);
    check("lu_stall_clr", 32'(stall_if_id), 32'd0);
    tick();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_rs1", 32'(ex_rs1), 32'd5);
    check("lu_add_rd", 32'(ex_rd), 32'd6);

    // Load to x0 never stalls
    drv_load(5'd0, 5'd2);
    tick();
    drv_alu(5'd6, 5'd0, 5'd1, 32'd0, 32'd3);
    #1;
    check("x0_nostall", 32'(stall_if_id), 32'd0);
    tick();
    check("x0_add_valid", 32'(ex_valid), 32'd1);

    // Store after load, dependency through rs2
    drv_load(5'd7, 5'd2);
    tick();
    drv_store(5'd2, 5'd7);
    #1;
    check("st_stall", 32'(stall_if_id), 32'd1);
    tick();
    check("st_bubble", 32'(ex_valid), 32'd0);
    tick();
    check("st_valid", 32'(ex_valid), 32'd1);
    check("st_ram_we", 32'(ex_ram_we), 32'd1);
    check("st_rd2", ex_rd2, 32'hCAFE);

    // Flush beats stall
    drv_load(5'd8, 5'd2);
    tick();
    drv_alu(5'd9, 5'd8, 5'd0, 32'd1, 32'd2);
    ex_flush = 1'b1;
    #1;
    check("fs_stall", 32'(stall_if_id), 32'd0);
    check("fs_flush", 32'(flush_if_id), 32'd1);
    tick();
    ex_flush = 1'b0;
    check("fs_bubble", 32'(ex_valid), 32'd0);
    check("fs_npc", 32'(ex_npc_op), 32'(NPC_PC4));

    // Flush with no hazard, JAL in ID
    drv_jal(5'd1);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    check("fl_bubble", 32'(ex_valid), 32'd0);
    check("fl_npc", 32'(ex_npc_op), 32'(NPC_PC4));

    // Empty ID slot yields a bubble after a valid capture
    drv_alu(5'd4, 5'd1, 5'd2, 32'd9, 32'd9);
    tick();
    check("nop_pre", 32'(ex_valid), 32'd1);
    drv_nop();
    tick();
    check("nop_bubble", 32'(ex_valid), 32'd0);

    // Third load-use event: dependent load after load
    drv_load(5'd10, 5'd2);
    tick();
    drv_load(5'd11, 5'd10);
    #1;
    check("ll_stall", 32'(stall_if_id), 32'd1);
    tick();
    check("ll_bubble", 32'(ex_valid), 32'd0);
    tick();
    check("ll_valid", 32'(ex_valid), 32'd1);
    check("ll_rd", 32'(ex_rd), 32'd11);
    drv_nop();
    tick();

`ifdef ID_EX_PERF_CNT_EN
    check("cnt_stall", perf_stall_cnt, 32'd3);
    check("cnt_flush", perf_flush_cnt, 32'd2);
    drv_load(5'd12, 5'd2);
    tick();
    force dut.perf_stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.perf_stall_cnt;
    drv_alu(5'd13, 5'd12, 5'd1, 32'd0, 32'd0);
    tick();
    check("cnt_sat", perf_stall_cnt, 32'hFFFF_FFFF);
    drv_nop();
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
